// File: rtl/ciq_issue_queue.sv
// ciq_issue_queue: compacting centralized issue queue, oldest-first select.
// Define CIQ_PERF_CNT_EN to add perf_full_cycles / perf_issued counters.
module ciq_issue_queue #(
  parameter int ISSUE_NUM = 4,
  parameter int PRF_WIDTH = 6,
  parameter int CIQ_DEPTH = 16,
  parameter int FU_WIDTH  = 2
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic [1:0]                          disp_valid,
  output logic                                disp_ready,
  input  logic [1:0][PRF_WIDTH-1:0]           disp_prs1,
  input  logic [1:0][PRF_WIDTH-1:0]           disp_prs2,
  input  logic [1:0]                          disp_rs1_rdy,
  input  logic [1:0]                          disp_rs2_rdy,
  input  logic [1:0][PRF_WIDTH-1:0]           disp_prd,
  input  logic [1:0]                          disp_prd_v,
  input  logic [1:0][FU_WIDTH-1:0]            disp_fu,
  input  logic                                flush,
  output logic [CIQ_DEPTH-1:0][PRF_WIDTH-1:0] ciq_prs1,
  output logic [CIQ_DEPTH-1:0][PRF_WIDTH-1:0] ciq_prs2,
  input  logic [CIQ_DEPTH-1:0]                prs1_rdy,
  input  logic [CIQ_DEPTH-1:0]                prs2_rdy,
  input  logic                                muti_finish,
  output logic [ISSUE_NUM-1:0]                arbit_grant,
  output logic [ISSUE_NUM-1:0][PRF_WIDTH-1:0] arbit_prd,
  output logic [ISSUE_NUM-1:0]                arbit_prd_v,
  output logic [$clog2(CIQ_DEPTH):0]          ciq_count
`ifdef CIQ_PERF_CNT_EN
  ,
  output logic [31:0]                         perf_full_cycles,
  output logic [31:0]                         perf_issued
`endif
);

  localparam int IW = $clog2(CIQ_DEPTH);
  localparam logic [IW:0] ONE = (IW+1)'(1);
  localparam logic [IW:0] RDY_MAX = (IW+1)'(CIQ_DEPTH-2);

  typedef struct packed {
    logic                 v;
    logic [PRF_WIDTH-1:0] prs1;
    logic [PRF_WIDTH-1:0] prs2;
    logic                 rdy1;
    logic                 rdy2;
    logic [PRF_WIDTH-1:0] prd;
    logic                 prd_v;
    logic [FU_WIDTH-1:0]  fu;
  } ent_t;

  ent_t q [CIQ_DEPTH];
  ent_t d [CIQ_DEPTH];
  logic [CIQ_DEPTH-1:0] taken;
  logic [IW:0] idx;

  assign disp_ready = (ciq_count <= RDY_MAX);

  always_comb begin
    for (int k = 0; k < CIQ_DEPTH; k++) begin
      ciq_prs1[k] = q[k].v ? q[k].prs1 : '0;
      ciq_prs2[k] = q[k].v ? q[k].prs2 : '0;
    end
  end

  always_comb begin : sel
    logic found;
    taken       = '0;
    arbit_grant = '0;
    arbit_prd   = '0;
    arbit_prd_v = '0;
    found       = 1'b0;
    for (int p = 0; p < ISSUE_NUM; p++) begin
      found = 1'b0;
      for (int k = 0; k < CIQ_DEPTH; k++) begin
        if (!found && q[k].v && q[k].rdy1 && q[k].rdy2 &&
            q[k].fu == FU_WIDTH'(p) &&
            (p != 2 || muti_finish)) begin
          found          = 1'b1;
          taken[k]       = 1'b1;
          arbit_grant[p] = 1'b1;
          arbit_prd[p]   = q[k].prd;
          arbit_prd_v[p] = q[k].prd_v;
        end
      end
    end
  end

  // Survivors pack down in age order, then accepted slots append.
  always_comb begin
    for (int k = 0; k < CIQ_DEPTH; k++) d[k] = '0;
    idx = '0;
    if (!flush) begin
      for (int k = 0; k < CIQ_DEPTH; k++) begin
        if (q[k].v && !taken[k]) begin
          d[idx[IW-1:0]]      = q[k];
          d[idx[IW-1:0]].rdy1 = q[k].rdy1 | prs1_rdy[k];
          d[idx[IW-1:0]].rdy2 = q[k].rdy2 | prs2_rdy[k];
          idx = idx + ONE;
        end
      end
      for (int s = 0; s < 2; s++) begin
        if (disp_valid[s] && disp_ready) begin
          d[idx[IW-1:0]].v     = 1'b1;
          d[idx[IW-1:0]].prs1  = disp_prs1[s];
          d[idx[IW-1:0]].prs2  = disp_prs2[s];
          d[idx[IW-1:0]].rdy1  = disp_rs1_rdy[s] |
                                 (disp_prs1[s] == '0);
          d[idx[IW-1:0]].rdy2  = disp_rs2_rdy[s] |
                                 (disp_prs2[s] == '0);
          d[idx[IW-1:0]].prd   = disp_prd[s];
          d[idx[IW-1:0]].prd_v = disp_prd_v[s];
          d[idx[IW-1:0]].fu    = disp_fu[s];
          idx = idx + ONE;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < CIQ_DEPTH; k++) q[k] <= '0;
      ciq_count <= '0;
    end else begin
      for (int k = 0; k < CIQ_DEPTH; k++) q[k] <= d[k];
      ciq_count <= idx;
    end
  end

`ifdef CIQ_PERF_CNT_EN
  logic [31:0] gcnt;

  always_comb begin
    gcnt = '0;
    for (int p = 0; p < ISSUE_NUM; p++)
      gcnt = gcnt + 32'(arbit_grant[p]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_full_cycles <= '0;
      perf_issued      <= '0;
    end else begin
      if (!disp_ready)
        perf_full_cycles <= perf_full_cycles + 32'd1;
      perf_issued <= perf_issued + gcnt;
    end
  end
`endif

endmodule

// File: doc/ciq_issue_queue.md
# ciq_issue_queue

Compacting centralized issue queue (CIQ) with integrated oldest-first select. It sits directly upstream of `wake_up`. It stores dispatched micro-ops, exports every entry's source tags (`ciq_prs1`/`ciq_prs2`) to `wake_up`, and absorbs the returned `prs1_rdy`/`prs2_rdy`. Each cycle it grants at most one ready entry per issue port and drives the selected `arbit_prd`/`arbit_prd_v`/`arbit_grant` back to `wake_up` and to execute.

## Interface
- `ISSUE_NUM`, 4: number of issue ports. Port 2 is the multi-cycle mul/div port.
- `PRF_WIDTH`, 6: physical register tag width.
- `CIQ_DEPTH`, 16: number of entries. Must be ≥ 4.
- `FU_WIDTH`, 2: width of the port-select field; equals clog2(`ISSUE_NUM`).

Ports:
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `disp_valid` input 2: dispatch slot valid. Slot 0 is older than slot 1. Slots are independent.
- `disp_ready` output 1: queue accepts 2 micro-ops this cycle.
- `disp_prs1` / `disp_prs2` input [PRF_WIDTH-1:0] ×2: source tags per slot.
- `disp_rs1_rdy` / `disp_rs2_rdy` input 2: source already available (from the busy table).
- `disp_prd` input [PRF_WIDTH-1:0] ×2: destination tag per slot.
- `disp_prd_v` input 2: slot writes a destination.
- `disp_fu` input [FU_WIDTH-1:0] ×2: target issue port.
- `flush` input 1: discard all entries.
- `ciq_prs1` / `ciq_prs2` output [PRF_WIDTH-1:0] ×CIQ_DEPTH: per-entry source tags.
- `prs1_rdy` / `prs2_rdy` input 1 ×CIQ_DEPTH: per-entry wakeup match for the current cycle.
- `muti_finish` input 1: mul/div unit idle. Port 2 may grant only when this is 1.
- `arbit_grant` output ISSUE_NUM: port i issues this cycle.
- `arbit_prd` output [PRF_WIDTH-1:0] ×ISSUE_NUM: destination tag of the granted entry.
- `arbit_prd_v` output ISSUE_NUM: the granted entry has a destination.
- `ciq_count` output clog2(CIQ_DEPTH)+1: number of valid entries (registered).

## Operation
- **Entry state:** `v`, `prs1`, `prs2`, `rdy1`, `rdy2`, `prd`, `prd_v`, `fu`. Position encodes age; index 0 is oldest. Valid entries are always contiguous from index 0.
- **Zero tag:** a source tag of 0 is ready at dispatch, regardless of `disp_rs*_rdy`.
- **Wakeup:**
  - At each edge, a surviving entry's new `rdy1` = old `rdy1` | `prs1_rdy[k]`, where k is its pre-compaction index. `rdy2` is handled the same way.
  - Invalid entries drive 0 on `ciq_prs1`/`ciq_prs2`. Their `prs*_rdy` inputs are ignored.
- **Select (combinational from registered state):**
  - For each port p, the grant goes to the lowest-index entry with `v & rdy1 & rdy2 & fu==p`.
  - Port 2 additionally requires `muti_finish==1`.
  - `arbit_prd[p]`/`arbit_prd_v[p]` carry the granted entry's fields. When there is no grant, both are 0.
- **Removal and compaction:**
  - All granted entries (up to ISSUE_NUM) are removed at the edge.
  - Survivors shift down, preserving relative order.
  - New dispatches append after the survivors: slot 0 first, then slot 1.
- **Dispatch:**
  - `disp_ready = (ciq_count <= CIQ_DEPTH-2)`, computed from the registered count only. Same-cycle frees are not credited.
  - A slot is written only when `disp_valid[s] & disp_ready`.
- **Count update:** `ciq_count_next = ciq_count - popcount(arbit_grant) + accepted dispatches`.
- **Flush:** all `v` bits clear and `ciq_count` becomes 0 at the edge. Flush overrides same-cycle dispatch. `arbit_grant` is still driven combinationally in the flush cycle.

## Timing
- **Reset:** the `rst_n` assertion clears all `v`, `rdy*` and stored fields.
  - Output values during reset: `ciq_count=0`, `disp_ready=1`, `arbit_grant=0`, `arbit_prd=0`, `arbit_prd_v=0`, `ciq_prs*=0`.
  - Reset asserted mid-operation drops all entries immediately (asynchronously).
- **Dispatch latency:** an entry dispatched with both sources ready at edge N can be granted in cycle N+1.
- **Wakeup latency:** a `prs*_rdy` pulse in cycle t makes the entry eligible for select in cycle t+1. There is no same-cycle wake-to-grant, so there is no combinational loop through `wake_up`.
- **Grant/dispatch timing:** a grant in cycle t removes the entry at the end of t. The freed space raises `disp_ready` in t+1.
- **Full queue:** with `ciq_count ≥ CIQ_DEPTH-1`, `disp_ready=0`. Select and removal continue normally.
- **Empty queue:** all grants are 0.

## Configuration
- `CIQ_PERF_CNT_EN` defined: adds two 32-bit registered, wrapping outputs, both reset to 0:
  - `perf_full_cycles`: increments each cycle with `disp_ready==0`.
  - `perf_issued`: adds `popcount(arbit_grant)` each cycle.
- Not defined: both outputs and their logic are absent.

## Test plan
- **Reset:** hold `rst_n=0` for 3 cycles -> all outputs 0, `disp_ready=1`. Release, then dispatch slot 0 with prs1=0, prs2=0, fu=1, prd=9 -> next cycle `arbit_grant=4'b0010`, `arbit_prd[1]=9`.
- **Wakeup:** dispatch prs1=5 (not ready), prs2=0, fu=0. Pulse `prs1_rdy[0]` in cycle t -> grant on port 0 in t+1, not in t.
- **Age order:** dispatch two ready fu=0 ops (prd 3, then prd 4) -> prd 3 granted first, prd 4 one cycle later from index 0.
- **Mul/div gating:** a ready fu=2 entry with `muti_finish=0` -> no port-2 grant. Raise `muti_finish` -> grant in the same cycle.
- **Full queue:** fill to 15 entries, none ready -> `disp_ready=0`, count holds at 15. Grant one -> `disp_ready=1` next cycle.
- **Simultaneous events:** with 16 entries and 4 grants in the same cycle as `flush` -> `ciq_count=0` next cycle and the dispatch is dropped.
